// File: rtl/gate_chain_pkg.sv
// Shared types, defaults and gate primitives for the pipelined gate chain.
// Optional mode support is enabled with `define GATE_CHAIN_MODE_EN.
package gate_chain_pkg;

  typedef enum logic {
    GATE_NAND = 1'b0,
    GATE_NOR  = 1'b1
  } gate_op_e;

  localparam int GC_DEF_WIDTH  = 1;
  localparam int GC_DEF_STAGES = 2;
  localparam int GC_DEF_CNT_W  = 16;
  localparam int GC_MAX_STAGES = 8;

  function automatic logic gate_eval(input gate_op_e op, input logic x, input logic y);
    return (op == GATE_NOR) ? ~(x | y) : ~(x & y);
  endfunction

  // Closing gate: AND-NOT in NAND mode, OR-NOT in NOR mode.
  function automatic logic final_eval(input gate_op_e op, input logic f, input logic z);
    return (op == GATE_NOR) ? (~f | z) : (~f & z);
  endfunction

endpackage

// File: rtl/gate_chain_slot.sv
// One pipeline slot of the gate chain: valid bit, load/advance control and the gate it owns.
// Carries a per-transaction mode bit when GATE_CHAIN_MODE_EN is defined.
module gate_chain_slot
  import gate_chain_pkg::*;
#(
  parameter int WIDTH  = GC_DEF_WIDTH,
  parameter int STAGES = GC_DEF_STAGES,
  parameter int IDX    = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        prev_v,
  input  logic [WIDTH-1:0]            prev_p,
  input  logic [WIDTH-1:0]            prev_first,
  input  logic [(STAGES+2)*WIDTH-1:0] prev_ops,
`ifdef GATE_CHAIN_MODE_EN
  input  logic                        prev_mode,
  output logic                        mode_o,
`endif
  input  logic                        adv_i,
  output logic                        ld_o,
  output logic                        v_o,
  output logic [WIDTH-1:0]            p_o,
  output logic [WIDTH-1:0]            first_o,
  output logic [WIDTH-1:0]            f_o,
  output logic [(STAGES+2)*WIDTH-1:0] ops_o
);

  localparam int OPS_W = (STAGES + 2) * WIDTH;
  localparam int K     = IDX + 1;

  logic             v_q, v_d;
  logic [WIDTH-1:0] p_q, p_d, first_q, first_d, f_q, f_d;
  logic [OPS_W-1:0] ops_q, ops_d;
  logic [WIDTH-1:0] x, y, g, fin;
  gate_op_e         op;

`ifdef GATE_CHAIN_MODE_EN
  logic mode_q, mode_d;
  assign op     = prev_mode ? GATE_NOR : GATE_NAND;
  assign mode_o = mode_q;
`else
  assign op = GATE_NAND;
`endif

  // Slot 0 gates op0 with op1; later slots gate the upstream partial with op[IDX+1].
  assign x    = (IDX == 0) ? prev_ops[WIDTH-1:0] : prev_p;
  assign y    = prev_ops[K*WIDTH +: WIDTH];
  assign ld_o = !v_q || adv_i;

  always_comb begin
    v_d     = ld_o ? prev_v : v_q;
    p_d     = p_q;
    first_d = first_q;
    f_d     = f_q;
    ops_d   = ops_q;
    g       = '0;
    fin     = '0;
`ifdef GATE_CHAIN_MODE_EN
    mode_d  = mode_q;
`endif
    for (int b = 0; b < WIDTH; b++) begin
      g[b]   = gate_eval(op, x[b], y[b]);
      fin[b] = final_eval(op, x[b], y[b]);
    end
    // Data only moves with a valid transaction, so idle operand bits never enter the pipe.
    if (ld_o && prev_v) begin
      ops_d = prev_ops;
`ifdef GATE_CHAIN_MODE_EN
      mode_d = prev_mode;
`endif
      if (IDX == 0) begin
        p_d     = g;
        first_d = g;
      end else if (IDX == STAGES) begin
        p_d     = fin;
        f_d     = prev_p;
        first_d = prev_first;
      end else begin
        p_d     = g;
        first_d = prev_first;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q     <= 1'b0;
      p_q     <= '0;
      first_q <= '0;
      f_q     <= '0;
      ops_q   <= '0;
`ifdef GATE_CHAIN_MODE_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      v_q     <= v_d;
      p_q     <= p_d;
      first_q <= first_d;
      f_q     <= f_d;
      ops_q   <= ops_d;
`ifdef GATE_CHAIN_MODE_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign v_o     = v_q;
  assign p_o     = p_q;
  assign first_o = first_q;
  assign f_o     = f_q;
  assign ops_o   = ops_q;

endmodule

// File: rtl/gate_chain_pipe.sv
// Pipelined NAND chain with closing AND-NOT, valid/ready on both sides and a result counter.
// Defining GATE_CHAIN_MODE_EN adds in_mode/out_mode to switch a transaction to the NOR chain.
module gate_chain_pipe
  import gate_chain_pkg::*;
#(
  parameter int WIDTH  = GC_DEF_WIDTH,
  parameter int STAGES = GC_DEF_STAGES,
  parameter int CNT_W  = GC_DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [(STAGES+2)*WIDTH-1:0] in_ops,
`ifdef GATE_CHAIN_MODE_EN
  input  logic                        in_mode,
  output logic                        out_mode,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_first,
  output logic [WIDTH-1:0]            out_last,
  output logic [WIDTH-1:0]            out_result,
  output logic [CNT_W-1:0]            out_count
);

  localparam int OPS_W = (STAGES + 2) * WIDTH;

  // Index 0 of each array is the input side; slot i reads [i] and drives [i+1].
  logic [STAGES+1:0] v_w;
  logic [STAGES+1:0] ld_w;
  logic [WIDTH-1:0]  p_w     [0:STAGES+1];
  logic [WIDTH-1:0]  first_w [0:STAGES+1];
  logic [WIDTH-1:0]  f_w     [0:STAGES+1];
  logic [OPS_W-1:0]  ops_w   [0:STAGES+1];
`ifdef GATE_CHAIN_MODE_EN
  logic [STAGES+1:0] mode_w;
  assign mode_w[0] = in_mode;
  assign out_mode  = mode_w[STAGES+1];
`endif

  assign v_w[0]          = in_valid;
  assign p_w[0]          = '0;
  assign first_w[0]      = '0;
  assign f_w[0]          = '0;
  assign ops_w[0]        = in_ops;
  assign ld_w[STAGES+1]  = out_ready;

  for (genvar gi = 0; gi <= STAGES; gi++) begin : g_slot
    gate_chain_slot #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .IDX    (gi)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .prev_v     (v_w[gi]),
      .prev_p     (p_w[gi]),
      .prev_first (first_w[gi]),
      .prev_ops   (ops_w[gi]),
`ifdef GATE_CHAIN_MODE_EN
      .prev_mode  (mode_w[gi]),
      .mode_o     (mode_w[gi+1]),
`endif
      .adv_i      (ld_w[gi+1]),
      .ld_o       (ld_w[gi]),
      .v_o        (v_w[gi+1]),
      .p_o        (p_w[gi+1]),
      .first_o    (first_w[gi+1]),
      .f_o        (f_w[gi+1]),
      .ops_o      (ops_w[gi+1])
    );
  end

  // Ready depends only on slot state and out_ready, and is held low during reset.
  assign in_ready   = !rst && ld_w[0];
  assign out_valid  = v_w[STAGES+1];
  assign out_first  = first_w[STAGES+1];
  assign out_last   = f_w[STAGES+1];
  assign out_result = p_w[STAGES+1];

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign out_count = cnt_q;

endmodule

// File: tb/tb_gate_chain_pipe.sv
// Bench for gate_chain_pipe: truth table, streaming, backpressure, reset and counter wrap.
module tb_gate_chain_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h with nothing expected", nm, act);
  endtask

  // Reference: chain evaluated straight from the gate rules, lanes masked to w bits.
  function automatic logic [23:0] ref_chain(input logic [79:0] ops, input int w, input int s,
                                            input logic mode);
    logic [7:0] m, o0, o1, e, p, z, r;
    m  = 8'((1 << w) - 1);
    o0 = 8'(ops) & m;
    o1 = 8'(ops >> w) & m;
    e  = (mode ? ~(o0 | o1) : ~(o0 & o1)) & m;
    p  = e;
    for (int i = 1; i < s; i++) begin
      z = 8'(ops >> ((i + 1) * w)) & m;
      p = (mode ? ~(p | z) : ~(p & z)) & m;
    end
    z = 8'(ops >> ((s + 1) * w)) & m;
    r = (mode ? (~p | z) : (~p & z)) & m;
    return {e, p, r};
  endfunction

  // Instance A: WIDTH=1, STAGES=2 (classic a,b,c,d -> e,f,g)
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [3:0]  a_ops;
  logic        a_first, a_last, a_res;
  logic [15:0] a_cnt;
`ifdef GATE_CHAIN_MODE_EN
  logic        a_mode, a_out_mode;
`endif

  gate_chain_pipe #(.WIDTH(1), .STAGES(2), .CNT_W(16)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .in_ops     (a_ops),
`ifdef GATE_CHAIN_MODE_EN
    .in_mode    (a_mode),
    .out_mode   (a_out_mode),
`endif
    .out_valid  (a_out_valid),
    .out_ready  (a_out_ready),
    .out_first  (a_first),
    .out_last   (a_last),
    .out_result (a_res),
    .out_count  (a_cnt)
  );

  // Instance B: WIDTH=8, STAGES=4
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_mode;
  logic [47:0] b_ops;
  logic [7:0]  b_first, b_last, b_res;
  logic [15:0] b_cnt;
`ifdef GATE_CHAIN_MODE_EN
  logic        b_out_mode;
`endif

  gate_chain_pipe #(.WIDTH(8), .STAGES(4), .CNT_W(16)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .in_ops     (b_ops),
`ifdef GATE_CHAIN_MODE_EN
    .in_mode    (b_mode),
    .out_mode   (b_out_mode),
`endif
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .out_first  (b_first),
    .out_last   (b_last),
    .out_result (b_res),
    .out_count  (b_cnt)
  );

  // Instance C: WIDTH=4, STAGES=3, CNT_W=4 (counter wrap)
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_mode;
  logic [19:0] c_ops;
  logic [3:0]  c_first, c_last, c_res;
  logic [3:0]  c_cnt;
`ifdef GATE_CHAIN_MODE_EN
  logic        c_out_mode;
`endif

  gate_chain_pipe #(.WIDTH(4), .STAGES(3), .CNT_W(4)) dut_c (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (c_in_valid),
    .in_ready   (c_in_ready),
    .in_ops     (c_ops),
`ifdef GATE_CHAIN_MODE_EN
    .in_mode    (c_mode),
    .out_mode   (c_out_mode),
`endif
    .out_valid  (c_out_valid),
    .out_ready  (c_out_ready),
    .out_first  (c_first),
    .out_last   (c_last),
    .out_result (c_res),
    .out_count  (c_cnt)
  );

  // Scoreboards for B and C: expected {mode, first, last, result} in acceptance order.
  logic [24:0] b_q[$];
  logic [24:0] c_q[$];
  int          b_seen = 0;
  int          c_seen = 0;

  always @(negedge clk) begin
    logic [24:0] ex;
    if (!rst) begin
      if (b_out_valid && b_out_ready) begin
        if (b_q.size() == 0) flag("b_unexpected_out", {8'h0, b_first, b_last, b_res});
        else begin
          ex = b_q.pop_front();
          chk("b_data", {8'h0, b_first, b_last, b_res}, {8'h0, ex[23:0]});
`ifdef GATE_CHAIN_MODE_EN
          chk("b_out_mode", {31'h0, b_out_mode}, {31'h0, ex[24]});
`endif
        end
        b_seen++;
      end
      if (b_in_valid && b_in_ready) b_q.push_back({b_mode, ref_chain(80'(b_ops), 8, 4, b_mode)});
      if (c_out_valid && c_out_ready) begin
        if (c_q.size() == 0) flag("c_unexpected_out", {20'h0, c_first, c_last, c_res});
        else begin
          ex = c_q.pop_front();
          chk("c_data", {20'h0, c_first, c_last, c_res}, {20'h0, ex[19:16], ex[11:8], ex[3:0]});
        end
        c_seen++;
      end
      if (c_in_valid && c_in_ready) c_q.push_back({c_mode, ref_chain(80'(c_ops), 4, 3, c_mode)});
    end
  end

  typedef struct {
    logic [3:0] abcd;
    logic [2:0] efg;
  } tt_t;
  tt_t tt [16];

  logic [3:0]  n;
  logic [23:0] snap;
  logic        acc, have;
  int          lat, sent, stall, acc_n, stable_bad, seen0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tt = '{'{4'h0, 3'b110}, '{4'h1, 3'b110}, '{4'h2, 3'b100}, '{4'h3, 3'b101},
           '{4'h4, 3'b110}, '{4'h5, 3'b110}, '{4'h6, 3'b100}, '{4'h7, 3'b101},
           '{4'h8, 3'b110}, '{4'h9, 3'b110}, '{4'hA, 3'b100}, '{4'hB, 3'b101},
           '{4'hC, 3'b010}, '{4'hD, 3'b010}, '{4'hE, 3'b010}, '{4'hF, 3'b010}};

    rst = 1'b1;
    a_in_valid = 0; a_out_ready = 1; a_ops = '0;
    b_in_valid = 0; b_out_ready = 1; b_ops = '0; b_mode = 0;
    c_in_valid = 0; c_out_ready = 1; c_ops = '0; c_mode = 0;
`ifdef GATE_CHAIN_MODE_EN
    a_mode = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_out_valid", {31'h0, a_out_valid}, 0);
    chk("rst_a_results", {29'h0, a_first, a_last, a_res}, 0);
    chk("rst_a_in_ready", {31'h0, a_in_ready}, 0);
    chk("rst_b_out_valid", {31'h0, b_out_valid}, 0);
    chk("rst_b_results", {8'h0, b_first, b_last, b_res}, 0);
    chk("rst_b_count", {16'h0, b_cnt}, 0);
    chk("rst_c_count", {28'h0, c_cnt}, 0);
    rst = 1'b0;
    #1;
    chk("rel_a_in_ready", {31'h0, a_in_ready}, 1);
    chk("rel_b_in_ready", {31'h0, b_in_ready}, 1);
    @(posedge clk); #1;

    // Truth table, one transaction at a time, latency measured in edges after acceptance
    for (int i = 0; i < 16; i++) begin
      n = tt[i].abcd;
      a_ops = {n[0], n[1], n[2], n[3]};
      a_in_valid = 1;
      @(negedge clk);
      chk("tt_in_ready", {31'h0, a_in_ready}, 1);
      @(posedge clk); #1;
      a_in_valid = 0;
      lat = -1;
      for (int c = 1; c <= 8 && lat < 0; c++) begin
        @(posedge clk); #1;
        if (a_out_valid) lat = c;
      end
      chk("tt_latency", lat, 2);
      chk("tt_efg", {29'h0, a_first, a_last, a_res}, {29'h0, tt[i].efg});
    end
    @(posedge clk); #1;
    chk("tt_count", {16'h0, a_cnt}, 16);

`ifdef GATE_CHAIN_MODE_EN
    a_mode = 1; a_ops = 4'b0000; a_in_valid = 1;
    @(posedge clk); #1;
    a_in_valid = 0;
    lat = -1;
    for (int c = 1; c <= 8 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (a_out_valid) lat = c;
    end
    chk("mode_nor_latency", lat, 2);
    chk("mode_nor_efg", {29'h0, a_first, a_last, a_res}, 32'b101);
    chk("mode_nor_out_mode", {31'h0, a_out_mode}, 1);
    a_mode = 0;
    @(posedge clk); #1;
`endif

    // Streaming: 32 back-to-back vectors into B
    sent = 0; stall = 0;
    b_ops = 48'({$urandom, $urandom});
`ifdef GATE_CHAIN_MODE_EN
    b_mode = 1'($urandom_range(0, 1));
`endif
    b_in_valid = 1;
    for (int c = 0; c < 200 && sent < 32; c++) begin
      @(negedge clk);
      acc = b_in_ready;
      if (!acc) stall++;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        b_ops = 48'({$urandom, $urandom});
`ifdef GATE_CHAIN_MODE_EN
        b_mode = 1'($urandom_range(0, 1));
`endif
      end
    end
    b_in_valid = 0;
    chk("stream_stalls", stall, 0);
    for (int c = 0; c < 20 && b_seen < 32; c++) @(posedge clk);
    #1;
    chk("stream_seen", b_seen, 32);
    chk("stream_count", {16'h0, b_cnt}, 32);

    // Backpressure: out_ready low for 10 cycles while offering data
    b_out_ready = 0; acc_n = 0; stable_bad = 0; have = 0;
    b_in_valid = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      acc = b_in_ready;
      if (b_out_valid) begin
        if (!have) begin
          snap = {b_first, b_last, b_res};
          have = 1;
        end else if ({b_first, b_last, b_res} !== snap) stable_bad++;
      end
      @(posedge clk); #1;
      if (acc) begin
        acc_n++;
        b_ops = 48'({$urandom, $urandom});
`ifdef GATE_CHAIN_MODE_EN
        b_mode = 1'($urandom_range(0, 1));
`endif
      end
    end
    b_in_valid = 0;
    chk("bp_accepts", acc_n, 5);
    chk("bp_in_ready_low", {31'h0, b_in_ready}, 0);
    chk("bp_out_valid", {31'h0, b_out_valid}, 1);
    chk("bp_outputs_stable", stable_bad, 0);
    b_out_ready = 1;
    for (int c = 0; c < 20 && b_seen < 37; c++) @(posedge clk);
    #1;
    chk("bp_drain_seen", b_seen, 37);
    chk("bp_drain_count", {16'h0, b_cnt}, 37);

    // Reset with three transactions in flight
    b_in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      b_ops = 48'({$urandom, $urandom});
      @(posedge clk); #1;
    end
    b_in_valid = 0;
    #1;
    rst = 1'b1;
    #1;
    chk("rstmid_out_valid", {31'h0, b_out_valid}, 0);
    chk("rstmid_count", {16'h0, b_cnt}, 0);
    chk("rstmid_in_ready", {31'h0, b_in_ready}, 0);
    b_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rstmid_rel_in_ready", {31'h0, b_in_ready}, 1);
    seen0 = b_seen;
    repeat (10) @(posedge clk);
    #1;
    chk("rstmid_no_stale", b_seen - seen0, 0);
    chk("rstmid_idle_valid", {31'h0, b_out_valid}, 0);

    // Counter wrap on C with random output stalls
    sent = 0;
    c_ops = 20'($urandom);
    c_in_valid = 1;
    for (int c = 0; c < 400 && sent < 17; c++) begin
      c_out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = c_in_ready;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        c_ops = 20'($urandom);
      end
    end
    c_in_valid = 0;
    c_out_ready = 1;
    for (int c = 0; c < 40 && c_seen < 17; c++) @(posedge clk);
    #1;
    chk("wrap_seen", c_seen, 17);
    chk("wrap_count", {28'h0, c_cnt}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
